// File: rtl/uart_receiver_control.sv
// uart_receiver_control
// Receive-path sequencer for the UART. It validates the start bit with
// OVERSAMPLE x oversampling and emits one mid-bit shift pulse per frame bit.
// At end of frame it strobes error_check, evaluates parity/framing/break,
// loads the RBR and maintains the line-status flags.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a high-to-low transition on the line
// START  | counting to the start-bit mid-point, rejecting false starts
// SHIFT  | one receive_shift_en pulse per bit mid-point (data/parity/stop)
// CHECK  | one pclk: raise error_check towards the shift block
// LOAD   | one pclk: load RBR, update DR/OE/PE/FE/BI, back to IDLE
module uart_receiver_control #(
  parameter int OVERSAMPLE = 16,
  parameter int MID_SAMPLE = OVERSAMPLE / 2
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       baud_tick,
  input  logic       uart_rxd,
  input  logic       loop,
  input  logic       loop_txd,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic [7:0] rsr_data,
  input  logic       received_parity,
  input  logic       frame_error,
  input  logic       rbr_rd,
  input  logic       lsr_rd,
  output logic       receive_shift_en,
  output logic       error_check,
  output logic [7:0] rbr_data,
  output logic       data_ready,
  output logic       overrun_error,
  output logic       parity_error,
  output logic       framing_error,
  output logic       break_int,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(MID_SAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_CHECK,
    S_LOAD
  } state_t;

  state_t        state_q;
  logic [TW-1:0] tick_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic [3:0]    nbits_q;
  logic          line_prev_q;
  logic          shift_en_q;
  logic          err_chk_q;
  logic          rxd_meta_q;
  logic          rxd_sync_q;
  logic          line;

  logic [7:0]    rbr_q, rbr_d;
  logic          dr_q, dr_d;
  logic          oe_q, oe_d;
  logic          pe_q, pe_d;
  logic          fe_q, fe_d;
  logic          bi_q, bi_d;

  logic          par_x;
  logic          pe_n;
  logic          fe_n;
  logic          bi_n;

  // Two-flop synchronizer for the asynchronous serial input, idling high.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  assign line = loop ? loop_txd : rxd_sync_q;

  // Frame sequencer with registered single-pclk shift and check pulses.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      nbits_q     <= '0;
      line_prev_q <= 1'b1;
      shift_en_q  <= 1'b0;
      err_chk_q   <= 1'b0;
    end else begin
      shift_en_q <= 1'b0;
      err_chk_q  <= 1'b0;
      // Tracked in every state so a line still low after a frame cannot
      // look like a fresh falling edge once IDLE is re-entered.
      if (baud_tick) line_prev_q <= line;
      case (state_q)
        S_IDLE: begin
          if (baud_tick && line_prev_q && !line) begin
            state_q    <= S_START;
            tick_cnt_q <= '0;
            nbits_q    <= {2'b00, wls} + 4'd6 + {3'b000, pen};
          end
        end
        S_START: begin
          if (baud_tick) begin
            if (tick_cnt_q == TICK_MID) begin
              if (line) begin
                state_q <= S_IDLE;
              end else begin
                state_q    <= S_SHIFT;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (baud_tick) begin
            if (tick_cnt_q == TICK_LAST) begin
              shift_en_q <= 1'b1;
              tick_cnt_q <= '0;
              bit_cnt_q  <= bit_cnt_q + 4'd1;
              if (bit_cnt_q + 4'd1 == nbits_q) state_q <= S_CHECK;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        S_CHECK: begin
          err_chk_q <= 1'b1;
          state_q   <= S_LOAD;
        end
        S_LOAD: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Error evaluation is done in LOAD, the cycle in which error_check is
  // high and the shift block guarantees frame_error is valid.
  assign par_x = (^rsr_data) ^ received_parity;

  always_comb begin
    pe_n = 1'b0;
    if (pen) begin
      if (sp) pe_n = (received_parity != ~eps);
      else    pe_n = eps ? par_x : ~par_x;
    end
  end

  assign fe_n = frame_error;
  assign bi_n = (rsr_data == 8'h00) & (~pen | ~received_parity) & frame_error;

  // Line-status next state: reads clear, LOAD sets, and a set wins over a clear.
  always_comb begin
    rbr_d = rbr_q;
    dr_d  = dr_q;
    oe_d  = oe_q;
    pe_d  = pe_q;
    fe_d  = fe_q;
    bi_d  = bi_q;
    if (rbr_rd) dr_d = 1'b0;
    if (lsr_rd) begin
      oe_d = 1'b0;
      pe_d = 1'b0;
      fe_d = 1'b0;
      bi_d = 1'b0;
    end
    if (state_q == S_LOAD) begin
      rbr_d = rsr_data;
      dr_d  = 1'b1;
      if (dr_q && !rbr_rd) oe_d = 1'b1;
      pe_d = pe_d | pe_n;
      fe_d = fe_d | fe_n;
      bi_d = bi_d | bi_n;
    end
  end

  // Receive buffer and line-status flag registers.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rbr_q <= '0;
      dr_q  <= 1'b0;
      oe_q  <= 1'b0;
      pe_q  <= 1'b0;
      fe_q  <= 1'b0;
      bi_q  <= 1'b0;
    end else begin
      rbr_q <= rbr_d;
      dr_q  <= dr_d;
      oe_q  <= oe_d;
      pe_q  <= pe_d;
      fe_q  <= fe_d;
      bi_q  <= bi_d;
    end
  end

  assign receive_shift_en = shift_en_q;
  assign error_check      = err_chk_q;
  assign rbr_data         = rbr_q;
  assign data_ready       = dr_q;
  assign overrun_error    = oe_q;
  assign parity_error     = pe_q;
  assign framing_error    = fe_q;
  assign break_int        = bi_q;
  assign rx_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver_control.sv
// Bench for uart_receiver_control: drives serial frames, models the shift
// block, and checks each frame's outcome through a scoreboard queue.
module tb_uart_receiver_control;

  localparam int OS = 16;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       loop = 1'b0;
  logic       loop_txd = 1'b1;
  logic [1:0] wls = 2'b11;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sp = 1'b0;
  logic [7:0] rsr_data = 8'h00;
  logic       received_parity = 1'b0;
  logic       frame_error = 1'b0;
  logic       rbr_rd = 1'b0;
  logic       lsr_rd = 1'b0;
  logic       receive_shift_en;
  logic       error_check;
  logic [7:0] rbr_data;
  logic       data_ready;
  logic       overrun_error;
  logic       parity_error;
  logic       framing_error;
  logic       break_int;
  logic       rx_busy;

  uart_receiver_control #(.OVERSAMPLE(OS)) dut (
    .pclk(pclk), .preset(preset), .baud_tick(baud_tick), .uart_rxd(uart_rxd),
    .loop(loop), .loop_txd(loop_txd), .wls(wls), .pen(pen), .eps(eps), .sp(sp),
    .rsr_data(rsr_data), .received_parity(received_parity), .frame_error(frame_error),
    .rbr_rd(rbr_rd), .lsr_rd(lsr_rd), .receive_shift_en(receive_shift_en),
    .error_check(error_check), .rbr_data(rbr_data), .data_ready(data_ready),
    .overrun_error(overrun_error), .parity_error(parity_error),
    .framing_error(framing_error), .break_int(break_int), .rx_busy(rx_busy)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc++;

  int div = 1;
  int tick_ph = 0;
  always @(negedge pclk) begin
    tick_ph   = (tick_ph + 1 >= div) ? 0 : tick_ph + 1;
    baud_tick = (tick_ph == 0);
  end

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    int         nbits;
    logic [7:0] rbr;
    bit         dr, oe, pe, fe, bi;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;

  // reference model of the line-status state
  bit         m_dr, m_oe, m_pe, m_fe, m_bi;
  logic [7:0] m_rbr;

  bit cur_line = 1'b1;
  bit rd_at_load = 1'b0;
  int edge_cyc = 0;
  int sb_idx = 0;
  int pulses_in_frame = 0;
  int pulse_total = 0;
  int last_pulse_cyc = 0;
  int nd_mon;
  bit cmp_pend = 1'b0;

  // Monitor plus behavioural shift block: collect bits on each shift pulse,
  // pop the expected outcome on error_check, compare the flags one pclk later.
  always @(negedge pclk) begin
    if (preset) begin
      sb_idx = 0;
      pulses_in_frame = 0;
      cmp_pend = 1'b0;
    end else begin
      if (cmp_pend) begin
        chk("rbr_data", rbr_data, cur_e.rbr);
        chk("data_ready", data_ready, cur_e.dr);
        chk("overrun_error", overrun_error, cur_e.oe);
        chk("parity_error", parity_error, cur_e.pe);
        chk("framing_error", framing_error, cur_e.fe);
        chk("break_int", break_int, cur_e.bi);
        cmp_pend = 1'b0;
      end
      if (receive_shift_en) begin
        if (pulses_in_frame == 0) begin
          if (div == 1) chk("first_pulse_time", cyc - edge_cyc, loop ? 25 : 27);
        end else begin
          chk("pulse_spacing", cyc - last_pulse_cyc, OS * div);
        end
        last_pulse_cyc = cyc;
        pulses_in_frame++;
        pulse_total++;
        nd_mon = int'(wls) + 5;
        if (sb_idx == 0) begin
          rsr_data = 8'h00;
          received_parity = 1'b0;
          frame_error = 1'b0;
        end
        if (sb_idx < nd_mon) rsr_data[sb_idx] = cur_line;
        else if (pen && sb_idx == nd_mon) received_parity = cur_line;
        else frame_error = !cur_line;
        sb_idx++;
      end
      if (error_check) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_error_check", 1, 0);
        end else begin
          cur_e = exp_q.pop_front();
          chk("pulse_count", pulses_in_frame, cur_e.nbits);
          chk("error_check_latency", cyc - last_pulse_cyc, 1);
          cmp_pend = 1'b1;
        end
        pulses_in_frame = 0;
        sb_idx = 0;
      end
    end
  end

  initial begin
    repeat (90000) @(posedge pclk);
    $display("FAIL watchdog: cycle budget expired, got %0d checks expected completion", checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge pclk);
    rbr_rd = rd_at_load && error_check;
    lsr_rd = 1'b0;
  endtask

  task automatic hold(input int ticks);
    repeat (ticks * div) step();
  endtask

  task automatic set_line(input bit b);
    cur_line = b;
    if (loop) begin
      loop_txd = b;
      uart_rxd = 1'b1;
    end else begin
      uart_rxd = b;
      loop_txd = 1'($urandom);
    end
  endtask

  task automatic set_cfg(input int dv, input bit lp, input logic [1:0] w,
                         input bit pn, input bit ep, input bit s);
    step();
    uart_rxd = 1'b1;
    loop_txd = 1'b1;
    cur_line = 1'b1;
    hold(3);
    div = dv;
    loop = lp;
    wls = w;
    pen = pn;
    eps = ep;
    sp = s;
    hold(3);
  endtask

  task automatic model_reset();
    m_dr = 0; m_oe = 0; m_pe = 0; m_fe = 0; m_bi = 0; m_rbr = 8'h00;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_rbr"}, rbr_data, m_rbr);
    chk({tag, "_dr"}, data_ready, m_dr);
    chk({tag, "_oe"}, overrun_error, m_oe);
    chk({tag, "_pe"}, parity_error, m_pe);
    chk({tag, "_fe"}, framing_error, m_fe);
    chk({tag, "_bi"}, break_int, m_bi);
    chk({tag, "_busy"}, rx_busy, 0);
  endtask

  // Send one frame: start, data LSB first, optional parity, one stop bit,
  // an optional extra low tail after the stop bit, then idle high.
  task automatic send_frame(input logic [7:0] d, input bit pb, input bit sb,
                            input bit rdl, input int tail, input int idle);
    int nd;
    logic [7:0] data;
    bit pe_x, fe_x, bi_x;
    exp_t e;
    nd = int'(wls) + 5;
    data = d & 8'((1 << nd) - 1);
    pe_x = 1'b0;
    if (pen) begin
      if (sp) pe_x = (pb == eps);
      else if (eps) pe_x = ($countones({data, pb}) % 2) == 1;
      else pe_x = ($countones({data, pb}) % 2) == 0;
    end
    fe_x = !sb;
    bi_x = (data == 8'h00) && (!pen || !pb) && !sb;
    if (m_dr && !rdl) m_oe = 1;
    m_dr = 1;
    m_rbr = data;
    m_pe = m_pe | pe_x;
    m_fe = m_fe | fe_x;
    m_bi = m_bi | bi_x;
    e.nbits = nd + int'(pen) + 1;
    e.rbr = m_rbr; e.dr = m_dr; e.oe = m_oe; e.pe = m_pe; e.fe = m_fe; e.bi = m_bi;
    exp_q.push_back(e);
    rd_at_load = rdl;
    step();
    set_line(1'b0);
    edge_cyc = cyc;
    hold(OS);
    for (int i = 0; i < nd; i++) begin
      set_line(data[i]);
      hold(OS);
    end
    if (pen) begin
      set_line(pb);
      hold(OS);
    end
    set_line(sb);
    hold(OS + tail);
    set_line(1'b1);
    hold(idle);
    rd_at_load = 1'b0;
  endtask

  task automatic read_rbr();
    step();
    rbr_rd = 1'b1;
    step();
    m_dr = 0;
    chk("dr_after_rbr_rd", data_ready, 0);
    chk("rbr_kept_after_rd", rbr_data, m_rbr);
  endtask

  task automatic read_lsr();
    step();
    lsr_rd = 1'b1;
    step();
    m_oe = 0; m_pe = 0; m_fe = 0; m_bi = 0;
    chk("oe_after_lsr_rd", overrun_error, 0);
    chk("pe_after_lsr_rd", parity_error, 0);
    chk("fe_after_lsr_rd", framing_error, 0);
    chk("bi_after_lsr_rd", break_int, 0);
    chk("dr_kept_after_lsr_rd", data_ready, m_dr);
  endtask

  initial begin
    int p0;
    logic [7:0] pdat;
    model_reset();
    repeat (3) step();
    chk("rst_shift_en", receive_shift_en, 0);
    chk("rst_error_check", error_check, 0);
    chk_all("rst");
    preset = 1'b0;
    step();

    // 8N1 0xA5 through the synchronizer
    set_cfg(1, 0, 2'b11, 0, 0, 0);
    send_frame(8'hA5, 0, 1, 0, 0, 4);
    read_rbr();

    // 7E1 0x35 with a wrong parity bit, then LSR read
    set_cfg(1, 0, 2'b10, 1, 1, 0);
    send_frame(8'h35, 1, 1, 0, 0, 4);
    read_lsr();

    // short glitch is a false start, then a good 0x12 in loopback
    set_cfg(1, 1, 2'b11, 0, 0, 0);
    p0 = pulse_total;
    step();
    set_line(1'b0);
    hold(4);
    set_line(1'b1);
    hold(20);
    chk("glitch_no_pulse", pulse_total - p0, 0);
    chk_all("glitch");
    send_frame(8'h12, 0, 1, 0, 0, 4);

    // 5N1 line held low for two frame times: a single break character
    set_cfg(1, 0, 2'b00, 0, 0, 0);
    p0 = pulse_total;
    send_frame(8'h00, 0, 0, 0, 7 * OS, OS);
    chk("break_single_char_pulses", pulse_total - p0, 6);
    chk_all("break");

    // overrun, then reads coinciding with LOAD
    set_cfg(1, 0, 2'b11, 0, 0, 0);
    read_rbr();
    read_lsr();
    send_frame(8'h11, 0, 1, 0, 0, 4);
    send_frame(8'h22, 0, 1, 0, 0, 4);
    read_lsr();
    send_frame(8'h11, 0, 1, 1, 0, 4);
    send_frame(8'h22, 0, 1, 1, 0, 4);

    // reset during bit 3, then a clean 0x5A
    pdat = 8'hC3;
    step();
    set_line(1'b0);
    edge_cyc = cyc;
    hold(OS);
    for (int i = 0; i < 3; i++) begin
      set_line(pdat[i]);
      hold(OS);
    end
    set_line(pdat[3]);
    hold(OS / 2);
    chk("busy_before_reset", rx_busy, 1);
    chk("dr_before_reset", data_ready, 1);
    #2 preset = 1'b1;
    #1;
    model_reset();
    chk("arst_shift_en", receive_shift_en, 0);
    chk("arst_error_check", error_check, 0);
    chk_all("arst");
    step();
    set_line(1'b1);
    hold(4);
    preset = 1'b0;
    hold(4);
    send_frame(8'h5A, 0, 1, 0, 0, 4);

    // randomized frames
    for (int n = 0; n < 40; n++) begin
      set_cfg($urandom_range(1, 3), 1'($urandom), 2'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom_range(0, 3) == 0));
      send_frame(8'($urandom), 1'($urandom), $urandom_range(0, 6) != 0,
                 $urandom_range(0, 3) == 0, 0, $urandom_range(2, 8));
      chk("rand_busy_idle", rx_busy, 0);
      if ($urandom_range(0, 9) < 4) read_rbr();
      if ($urandom_range(0, 9) < 3) read_lsr();
    end

    hold(20);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
